magnitude_monitor: RTL and testbench
====================================

MAGNITUDE_MONITOR -- requirements
Module: magnitude_monitor

Interface
REQ-001 The block SHALL have parameter WIN_LOG2, default 3, which sets the log2 of the moving-average window length (WIN = 2**WIN_LOG2 samples, legal range 1..4).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port ena, input, 1 bit: when low, all internal state and outputs SHALL hold and mag_valid SHALL be ignored.
REQ-005 The block SHALL have port mag_in, input, 8 bits: unsigned magnitude sample from the upstream sqrt(x^2+y^2) stage.
REQ-006 The block SHALL have port mag_valid, input, 1 bit: single-cycle strobe qualifying mag_in.
REQ-007 The block SHALL have ports thr_hi and thr_lo, input, 8 bits each: alarm set and clear thresholds (unsigned).
REQ-008 The block SHALL have port clear_peak, input, 1 bit: synchronous peak-register clear.
REQ-009 The block SHALL have port avg_out, output, 8 bits: registered moving average.
REQ-010 The block SHALL have port avg_valid, output, 1 bit: one-cycle pulse when avg_out updates.
REQ-011 The block SHALL have port peak_out, output, 8 bits: registered running maximum.
REQ-012 The block SHALL have port alarm, output, 1 bit: registered hysteresis alarm.

Function
REQ-013 A sample SHALL be accepted on a rising edge where ena=1 and mag_valid=1.
REQ-014 Accepted samples SHALL be written into a WIN-entry circular buffer, with the write pointer wrapping from WIN-1 to 0.
REQ-015 A running sum of width 8+WIN_LOG2 bits SHALL be updated as sum + new - oldest in the acceptance cycle and SHALL never overflow.
REQ-016 The sequencer SHALL have states FILL and RUN.
REQ-017 FILL SHALL count accepted samples 0..WIN-1 and SHALL move to RUN on acceptance of the WIN-th sample.
REQ-018 RUN SHALL persist until reset.
REQ-019 In RUN, including the transition sample, avg_out SHALL equal sum>>WIN_LOG2 (truncated) and avg_valid SHALL pulse high, both registered, with latency one cycle after the accepting edge.
REQ-020 In FILL, avg_out and avg_valid SHALL remain 0.
REQ-021 Alarm SHALL be evaluated on each new average in RUN: it SHALL set when the new average > thr_hi and SHALL clear when the new average < thr_lo; otherwise it SHALL hold.
REQ-022 If both alarm conditions are true (thr_lo > thr_hi), set SHALL win.
REQ-023 Alarm SHALL update on the same edge as avg_out.
REQ-024 Back-to-back mag_valid on consecutive cycles SHALL be accepted without loss; no backpressure exists.
REQ-025 peak_out SHALL become max(peak_out, mag_in) on each accepted sample, in both FILL and RUN.
REQ-026 When clear_peak=1 and ena=1, peak_out SHALL be cleared to 0.
REQ-027 When clear_peak coincides with an accepted sample, peak_out SHALL be set to mag_in.

Reset
REQ-028 While rst_n=0, avg_out, avg_valid, peak_out and alarm SHALL be 0, the buffer, sum, count and pointer SHALL be 0, and the state SHALL be FILL.
REQ-029 An assertion of rst_n mid-RUN SHALL discard the window, and a full WIN-sample refill SHALL be required before the next avg_valid.

Configuration
REQ-030 With macro MAG_MON_PEAK_EN defined, peak tracking SHALL operate per REQ-025..REQ-027.
REQ-031 With MAG_MON_PEAK_EN undefined, the peak register SHALL be absent, peak_out SHALL be constant 0 and clear_peak SHALL be ignored.

Structure
REQ-032 Shared package mag_mon_pkg SHALL hold the FILL/RUN state typedef and the default WIN_LOG2 constant.
REQ-033 The circular buffer and its pointer SHALL be a sub-module mag_window_buf, which returns the oldest entry combinationally and writes on accept.

Verification
REQ-034 The bench SHALL check: reset, then 8 samples of value 40 -> avg_valid only after the 8th, with avg_out=40; the first 7 samples give avg_valid=0.
REQ-035 The bench SHALL check: RUN at 40, then samples 200,200,200,200 -> avg_out 60,80,100,120 (one per accept, latency 1).
REQ-036 The bench SHALL check: thr_hi=100, thr_lo=50, averages 120 then 80 then 40 -> alarm 1, 1 (held), 0.
REQ-037 The bench SHALL check: samples 10,250,30, then clear_peak alone, then clear_peak with sample 7 -> peak_out 10,250,250,0,7; with MAG_MON_PEAK_EN undefined, peak_out=0 throughout.
REQ-038 The bench SHALL check: ena=0 with mag_valid pulses -> no output change; rst_n pulsed after 5 RUN samples -> all outputs 0 and 8 new samples are needed for avg_valid.
REQ-039 The bench SHALL check: mag_valid held high for 16 consecutive cycles of 255 -> avg_out=255 and no sum overflow.

Source files
------------

// File: rtl/mag_mon_pkg.sv
// ============================================================================
// Module      : mag_mon_pkg
// Description : Shared sequencer state type and default window size for the
//               magnitude monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mag_mon_pkg;

    localparam int unsigned C_WIN_LOG2_DEFAULT = 3;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } mag_state_t;

endpackage : mag_mon_pkg

`default_nettype wire

// File: rtl/mag_window_buf.sv
// ============================================================================
// Module      : mag_window_buf
// Description : WIN-entry circular sample buffer; presents the oldest entry
//               (the one about to be overwritten) combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mag_window_buf
    import mag_mon_pkg::*;
#(
    parameter int WIN_LOG2 = C_WIN_LOG2_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic [7:0] oldest
);

    localparam int C_WIN = 1 << WIN_LOG2;

    logic [7:0]          r_mem [C_WIN];
    logic [WIN_LOG2-1:0] r_wr_ptr;

    assign oldest = r_mem[r_wr_ptr];

    // Power-of-two depth: the pointer wraps from WIN-1 to 0 on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < C_WIN; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
        end
    end

endmodule : mag_window_buf

`default_nettype wire

// File: rtl/magnitude_monitor.sv
// ============================================================================
// Module      : magnitude_monitor
// Description : Moving average, hysteresis alarm and optional peak tracker for
//               an 8-bit magnitude stream. Define MAG_MON_PEAK_EN to build the
//               peak register; otherwise peak_out is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module magnitude_monitor
    import mag_mon_pkg::*;
#(
    parameter int WIN_LOG2 = C_WIN_LOG2_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] mag_in,
    input  logic       mag_valid,
    input  logic [7:0] thr_hi,
    input  logic [7:0] thr_lo,
    input  logic       clear_peak,
    output logic [7:0] avg_out,
    output logic       avg_valid,
    output logic [7:0] peak_out,
    output logic       alarm
);

    localparam int                  C_WIN        = 1 << WIN_LOG2;
    localparam int                  C_SUM_W      = 8 + WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] C_COUNT_LAST = WIN_LOG2'(C_WIN - 1);

    mag_state_t          r_state;
    logic [WIN_LOG2-1:0] r_count;
    logic [C_SUM_W-1:0]  r_sum;

    logic                w_accept;
    logic                w_avg_update;
    logic [7:0]          w_oldest;
    logic [C_SUM_W-1:0]  w_sum_next;
    logic [7:0]          w_avg;

    assign w_accept     = ena & mag_valid;
    assign w_avg_update = w_accept & ((r_state == RUN) | (r_count == C_COUNT_LAST));

    // The sum holds at most WIN full-scale samples, so C_SUM_W bits never overflow.
    assign w_sum_next = r_sum + C_SUM_W'(mag_in) - C_SUM_W'(w_oldest);
    assign w_avg      = w_sum_next[C_SUM_W-1:WIN_LOG2];

    mag_window_buf #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_window_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_accept),
        .wr_data (mag_in),
        .oldest  (w_oldest)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= FILL;
            r_count   <= '0;
            r_sum     <= '0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
            alarm     <= 1'b0;
        end else if (ena) begin
            avg_valid <= w_avg_update;
            if (w_accept) begin
                r_sum <= w_sum_next;
            end
            if (w_accept && (r_state == FILL)) begin
                r_count <= r_count + 1'b1;
                if (r_count == C_COUNT_LAST) begin
                    r_state <= RUN;
                end
            end
            // Set is tested first so it wins when thr_lo > thr_hi.
            if (w_avg_update) begin
                avg_out <= w_avg;
                if (w_avg > thr_hi) begin
                    alarm <= 1'b1;
                end else if (w_avg < thr_lo) begin
                    alarm <= 1'b0;
                end
            end
        end
    end

`ifdef MAG_MON_PEAK_EN
    logic [7:0] r_peak;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_peak <= '0;
        end else if (ena) begin
            if (w_accept) begin
                if (clear_peak || (mag_in > r_peak)) begin
                    r_peak <= mag_in;
                end
            end else if (clear_peak) begin
                r_peak <= '0;
            end
        end
    end

    assign peak_out = r_peak;
`else
    logic w_unused_clear_peak;

    assign w_unused_clear_peak = clear_peak;
    assign peak_out            = '0;
`endif

endmodule : magnitude_monitor

`default_nettype wire

// File: tb/tb_magnitude_monitor.sv
// ============================================================================
// Module      : tb_magnitude_monitor
// Description : Directed self-checking bench for magnitude_monitor (WIN=8);
//               peak expectations follow MAG_MON_PEAK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_magnitude_monitor;

`ifdef MAG_MON_PEAK_EN
    localparam bit c_peak_en = 1'b1;
`else
    localparam bit c_peak_en = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] mag_in;
    logic       mag_valid;
    logic [7:0] thr_hi;
    logic [7:0] thr_lo;
    logic       clear_peak;
    logic [7:0] avg_out;
    logic       avg_valid;
    logic [7:0] peak_out;
    logic       alarm;

    int total = 0;
    int bad   = 0;

    int ramp_avg[4]   = '{60, 80, 100, 120};
    int ramp_alarm[4] = '{0, 0, 0, 1};
    int drain_avg[4]  = '{115, 110, 105, 100};

    magnitude_monitor #(
        .WIN_LOG2 (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .mag_in     (mag_in),
        .mag_valid  (mag_valid),
        .thr_hi     (thr_hi),
        .thr_lo     (thr_lo),
        .clear_peak (clear_peak),
        .avg_out    (avg_out),
        .avg_valid  (avg_valid),
        .peak_out   (peak_out),
        .alarm      (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pk(input logic [7:0] v);
        return c_peak_en ? v : 8'd0;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, leave outputs ready to sample.
    task automatic step(input logic [7:0] v, input logic vld, input logic clr);
        mag_in     = v;
        mag_valid  = vld;
        clear_peak = clr;
        @(posedge clk);
        #1;
        mag_valid  = 1'b0;
        clear_peak = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b1;
        mag_in     = '0;
        mag_valid  = 1'b0;
        thr_hi     = 8'd100;
        thr_lo     = 8'd50;
        clear_peak = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_avg",   avg_out,   8'd0);
        check("rst_valid", avg_valid, 8'd0);
        check("rst_peak",  peak_out,  8'd0);
        check("rst_alarm", alarm,     8'd0);
        rst_n = 1'b1;

        // Fill with 40s: nothing until the 8th sample.
        for (int i = 0; i < 7; i++) begin
            step(8'd40, 1'b1, 1'b0);
            check("fill_valid", avg_valid, 8'd0);
            check("fill_avg",   avg_out,   8'd0);
        end
        step(8'd40, 1'b1, 1'b0);
        check("fill8_valid", avg_valid, 8'd1);
        check("fill8_avg",   avg_out,   8'd40);
        check("fill8_alarm", alarm,     8'd0);
        check("fill8_peak",  peak_out,  pk(8'd40));

        step(8'd0, 1'b0, 1'b0);
        check("idle_valid", avg_valid, 8'd0);
        check("idle_avg",   avg_out,   8'd40);

        // Ramp with 200s; alarm stays low at exactly thr_hi, sets above it.
        for (int i = 0; i < 4; i++) begin
            step(8'd200, 1'b1, 1'b0);
            check("ramp_valid", avg_valid, 8'd1);
            check("ramp_avg",   avg_out,   8'(ramp_avg[i]));
            check("ramp_alarm", alarm,     8'(ramp_alarm[i]));
        end

        for (int i = 0; i < 4; i++) begin
            step(8'd0, 1'b1, 1'b0);
            check("drain_avg",   avg_out, 8'(drain_avg[i]));
            check("drain_alarm", alarm,   8'd1);
        end

        step(8'd40, 1'b1, 1'b0);
        check("hyst80_avg",   avg_out, 8'd80);
        check("hyst80_alarm", alarm,   8'd1);
        step(8'd0, 1'b1, 1'b0);
        check("hyst55_avg",   avg_out, 8'd55);
        check("hyst55_alarm", alarm,   8'd1);
        step(8'd80, 1'b1, 1'b0);
        check("hyst40_avg",   avg_out, 8'd40);
        check("hyst40_alarm", alarm,   8'd0);

        // Crossed thresholds: both conditions true, set wins.
        thr_hi = 8'd10;
        thr_lo = 8'd200;
        step(8'd40, 1'b1, 1'b0);
        check("setwin_avg",   avg_out, 8'd20);
        check("setwin_alarm", alarm,   8'd1);
        thr_hi = 8'd100;
        thr_lo = 8'd50;

        // Peak tracking.
        step(8'd0, 1'b0, 1'b1);
        check("peak_clr0", peak_out, 8'd0);
        step(8'd10, 1'b1, 1'b0);
        check("peak_10",   peak_out, pk(8'd10));
        check("avg_21",    avg_out,  8'd21);
        check("alarm_clr", alarm,    8'd0);
        step(8'd250, 1'b1, 1'b0);
        check("peak_250",  peak_out, pk(8'd250));
        step(8'd30, 1'b1, 1'b0);
        check("peak_hold", peak_out, pk(8'd250));
        check("avg_56",    avg_out,  8'd56);
        step(8'd0, 1'b0, 1'b1);
        check("peak_clr",  peak_out, 8'd0);
        step(8'd7, 1'b1, 1'b1);
        check("peak_clr_sample", peak_out, pk(8'd7));
        check("avg_57",          avg_out,  8'd57);

        step(8'd0, 1'b0, 1'b0);
        check("pre_ena_valid", avg_valid, 8'd0);

        // ena low: strobes and clear_peak must be ignored.
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(8'd255, 1'b1, 1'b1);
            check("ena0_avg",   avg_out,   8'd57);
            check("ena0_valid", avg_valid, 8'd0);
            check("ena0_peak",  peak_out,  pk(8'd7));
            check("ena0_alarm", alarm,     8'd0);
        end
        ena = 1'b1;
        step(8'd0, 1'b1, 1'b0);
        check("ena1_avg",   avg_out,   8'd52);
        check("ena1_valid", avg_valid, 8'd1);

        // Reset mid-RUN, then a full refill is needed.
        for (int i = 0; i < 5; i++) begin
            step(8'd100, 1'b1, 1'b0);
        end
        rst_n = 1'b0;
        #2;
        check("mid_rst_avg",   avg_out,   8'd0);
        check("mid_rst_valid", avg_valid, 8'd0);
        check("mid_rst_peak",  peak_out,  8'd0);
        check("mid_rst_alarm", alarm,     8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(8'd16, 1'b1, 1'b0);
            check("refill_valid", avg_valid, 8'd0);
            check("refill_avg",   avg_out,   8'd0);
        end
        step(8'd16, 1'b1, 1'b0);
        check("refill8_valid", avg_valid, 8'd1);
        check("refill8_avg",   avg_out,   8'd16);
        check("refill8_peak",  peak_out,  pk(8'd16));

        // Full scale, back-to-back for 16 cycles.
        mag_in    = 8'd255;
        mag_valid = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("full8_avg",   avg_out,   8'd255);
        check("full8_valid", avg_valid, 8'd1);
        repeat (8) @(posedge clk);
        #1;
        mag_valid = 1'b0;
        check("full16_avg",   avg_out,   8'd255);
        check("full16_valid", avg_valid, 8'd1);
        check("full16_alarm", alarm,     8'd1);
        check("full16_peak",  peak_out,  pk(8'd255));
        step(8'd0, 1'b0, 1'b0);
        check("full_end_valid", avg_valid, 8'd0);
        check("full_end_avg",   avg_out,   8'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_magnitude_monitor

`default_nettype wire
